// File: rtl/cache_fe_arbiter_pkg.sv
// Shared definitions for the cache front-end arbiter: FSM state encoding and
// the grant-index width helper.
package cache_fe_arbiter_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_t;

   // Width of an index selecting one of n requesters (never less than 1 bit).
   function automatic int arb_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cache_fe_arbiter_rr_priority_enc.sv
// Combinational rotating priority encoder: picks the first set request bit
// scanning upward from ptr, wrapping modulo N.
module cache_fe_arbiter_rr_priority_enc #(
   parameter int N   = 2,
   parameter int M_W = 1
) (
   input  logic [N-1:0]   req,
   input  logic [M_W-1:0] ptr,
   output logic [M_W-1:0] sel,
   output logic           any_req
);

   logic [M_W-1:0] idx;

   // Walk offsets from the far end back to 0 so the nearest request wins.
   always_comb begin
      sel     = '0;
      idx     = '0;
      any_req = |req;
      for (int k = N - 1; k >= 0; k--) begin
         idx = M_W'((int'(ptr) + k) % N);
         if (req[idx]) sel = idx;
      end
   end

endmodule

// File: rtl/cache_fe_arbiter.sv
// Shares one cache front-end native port between N_MASTERS requesters with a
// registered, one-transaction grant. Define FE_ARB_FIXED_PRIO_EN for fixed priority.
module cache_fe_arbiter
   import cache_fe_arbiter_pkg::*;
#(
   parameter int  N_MASTERS  = 2,
   parameter int  FE_ADDR_W  = 32,
   parameter int  FE_DATA_W  = 32,
   parameter int  FE_NBYTES  = FE_DATA_W / 8,
   parameter int  CTRL_CACHE = 0,
   localparam int M_W        = arb_idx_w(N_MASTERS),
   localparam int AW         = CTRL_CACHE + FE_ADDR_W
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [N_MASTERS-1:0]           s_valid,
   input  logic [N_MASTERS*AW-1:0]        s_addr,
   input  logic [N_MASTERS*FE_DATA_W-1:0] s_wdata,
   input  logic [N_MASTERS*FE_NBYTES-1:0] s_wstrb,
   output logic [N_MASTERS-1:0]           s_ready,
   output logic [FE_DATA_W-1:0]           s_rdata,
   output logic                           m_valid,
   output logic [AW-1:0]                  m_addr,
   output logic [FE_DATA_W-1:0]           m_wdata,
   output logic [FE_NBYTES-1:0]           m_wstrb,
   input  logic                           m_ready,
   input  logic [FE_DATA_W-1:0]           m_rdata,
   output logic [M_W-1:0]                 grant,
   output logic                           busy
);

   arb_state_t     state, state_nxt;
   logic [M_W-1:0] grant_nxt;
   logic [M_W-1:0] sel;
   logic           any_req;

`ifdef FE_ARB_FIXED_PRIO_EN
   cache_fe_arbiter_rr_priority_enc #(.N(N_MASTERS), .M_W(M_W)) u_enc (
      .req     (s_valid),
      .ptr     ('0),
      .sel     (sel),
      .any_req (any_req)
   );
`else
   logic [M_W-1:0] rr_ptr, rr_ptr_nxt;

   cache_fe_arbiter_rr_priority_enc #(.N(N_MASTERS), .M_W(M_W)) u_enc (
      .req     (s_valid),
      .ptr     (rr_ptr),
      .sel     (sel),
      .any_req (any_req)
   );
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= ARB_IDLE;
         grant  <= '0;
`ifndef FE_ARB_FIXED_PRIO_EN
         rr_ptr <= '0;
`endif
      end else begin
         state  <= state_nxt;
         grant  <= grant_nxt;
`ifndef FE_ARB_FIXED_PRIO_EN
         rr_ptr <= rr_ptr_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt  = state;
      grant_nxt  = grant;
`ifndef FE_ARB_FIXED_PRIO_EN
      rr_ptr_nxt = rr_ptr;
`endif
      m_valid    = 1'b0;
      m_addr     = '0;
      m_wdata    = '0;
      m_wstrb    = '0;
      s_ready    = '0;
      case (state)
         ARB_IDLE: begin
            if (any_req) begin
               state_nxt = ARB_BUSY;
               grant_nxt = sel;
            end
         end
         ARB_BUSY: begin
            m_valid        = s_valid[grant];
            m_addr         = s_addr[int'(grant)*AW +: AW];
            m_wdata        = s_wdata[int'(grant)*FE_DATA_W +: FE_DATA_W];
            m_wstrb        = s_wstrb[int'(grant)*FE_NBYTES +: FE_NBYTES];
            s_ready[grant] = m_ready;
            if (m_ready) begin
               state_nxt  = ARB_IDLE;
`ifndef FE_ARB_FIXED_PRIO_EN
               rr_ptr_nxt = (grant == M_W'(N_MASTERS - 1)) ? '0 : grant + 1'b1;
`endif
            end else if (!s_valid[grant]) begin
               // Requester abandoned its request: release without moving the pointer.
               state_nxt = ARB_IDLE;
            end
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

   assign busy    = (state == ARB_BUSY);
   assign s_rdata = m_rdata;

endmodule

// File: tb/tb_cache_fe_arbiter.sv
// Directed plus randomized bench for cache_fe_arbiter against a cycle-level
// reference model of the arbitration rules (honours FE_ARB_FIXED_PRIO_EN).
module tb_cache_fe_arbiter;

   localparam int N  = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NB = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    s_valid;
   logic [N*AW-1:0] s_addr;
   logic [N*DW-1:0] s_wdata;
   logic [N*NB-1:0] s_wstrb;
   logic [N-1:0]    s_ready;
   logic [DW-1:0]   s_rdata;
   logic            m_valid;
   logic [AW-1:0]   m_addr;
   logic [DW-1:0]   m_wdata;
   logic [NB-1:0]   m_wstrb;
   logic            m_ready;
   logic [DW-1:0]   m_rdata;
   logic [0:0]      grant;
   logic            busy;

   int vectors     = 0;
   int miscompares = 0;

   // reference model state
   bit mbusy;
   int mgrant;
   int mptr;

   cache_fe_arbiter dut (
      .clk     (clk),
      .reset   (reset),
      .s_valid (s_valid),
      .s_addr  (s_addr),
      .s_wdata (s_wdata),
      .s_wstrb (s_wstrb),
      .s_ready (s_ready),
      .s_rdata (s_rdata),
      .m_valid (m_valid),
      .m_addr  (m_addr),
      .m_wdata (m_wdata),
      .m_wstrb (m_wstrb),
      .m_ready (m_ready),
      .m_rdata (m_rdata),
      .grant   (grant),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [N-1:0] exp_ready;
      exp_ready = '0;
      if (mbusy && m_ready) exp_ready[mgrant] = 1'b1;
      check_eq({tag, ".busy"},    64'(busy),    64'(mbusy));
      check_eq({tag, ".grant"},   64'(grant),   64'(mgrant));
      check_eq({tag, ".m_valid"}, 64'(m_valid), 64'(mbusy && s_valid[mgrant]));
      check_eq({tag, ".m_addr"},  64'(m_addr),  mbusy ? 64'(s_addr[mgrant*AW +: AW]) : 64'd0);
      check_eq({tag, ".m_wdata"}, 64'(m_wdata), mbusy ? 64'(s_wdata[mgrant*DW +: DW]) : 64'd0);
      check_eq({tag, ".m_wstrb"}, 64'(m_wstrb), mbusy ? 64'(s_wstrb[mgrant*NB +: NB]) : 64'd0);
      check_eq({tag, ".s_ready"}, 64'(s_ready), 64'(exp_ready));
      check_eq({tag, ".s_rdata"}, 64'(s_rdata), 64'(m_rdata));
   endtask

   // Advances the model by one clock using the inputs the DUT samples.
   task automatic model_update();
      bit found;
      found = 1'b0;
      if (!mbusy) begin
         for (int k = 0; k < N; k++) begin
            if (!found && s_valid[(mptr + k) % N]) begin
               found  = 1'b1;
               mgrant = (mptr + k) % N;
            end
         end
         if (found) mbusy = 1'b1;
      end else if (m_ready) begin
`ifndef FE_ARB_FIXED_PRIO_EN
         mptr = (mgrant + 1) % N;
`endif
         mbusy = 1'b0;
      end else if (!s_valid[mgrant]) begin
         mbusy = 1'b0;
      end
   endtask

   task automatic model_reset();
      mbusy  = 1'b0;
      mgrant = 0;
      mptr   = 0;
   endtask

   task automatic cycle(input string tag);
      #1;
      check_all(tag);
      @(posedge clk);
      model_update();
      #1;
   endtask

   initial begin
      int exp_g;
      reset   = 1'b1;
      s_valid = '0;
      s_addr  = '0;
      s_wdata = '0;
      s_wstrb = '0;
      m_ready = 1'b0;
      m_rdata = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      reset = 1'b0;

      // single read from requester 0
      s_valid         = 2'b01;
      s_addr[31:0]    = 32'h0000_48D0;
      s_wstrb         = '0;
      cycle("rd_arb");
      cycle("rd_wait1");
      cycle("rd_wait2");
      m_ready = 1'b1;
      m_rdata = 32'hDEAD_BEEF;
      #1;
      check_eq("rd_s_ready", 64'(s_ready), 64'h1);
      check_eq("rd_s_rdata", 64'(s_rdata), 64'hDEAD_BEEF);
      check_eq("rd_grant",   64'(grant),   64'h0);
      check_eq("rd_m_addr",  64'(m_addr),  64'h48D0);
      cycle("rd_done");
      m_ready = 1'b0;
      s_valid = '0;
      cycle("rd_idle");

      // write passthrough from requester 1
      s_valid       = 2'b10;
      s_addr[63:32] = 32'h0000_15E4;
      s_wdata[63:32] = 32'hCAFE_EFAC;
      s_wstrb[7:4]  = 4'hF;
      cycle("wr_arb");
      m_ready = 1'b1;
      #1;
      check_eq("wr_m_wdata", 64'(m_wdata), 64'hCAFE_EFAC);
      check_eq("wr_m_wstrb", 64'(m_wstrb), 64'hF);
      check_eq("wr_m_addr",  64'(m_addr),  64'h15E4);
      check_eq("wr_s_ready", 64'(s_ready), 64'h2);
      cycle("wr_done");
      m_ready = 1'b0;
      s_valid = '0;
      cycle("wr_idle");

      // contention: both valid, cache answers one cycle after m_valid
      s_valid = 2'b11;
      for (int t = 0; t < 6; t++) begin
`ifdef FE_ARB_FIXED_PRIO_EN
         exp_g = 0;
`else
         exp_g = t % 2;
`endif
         m_ready = 1'b0;
         cycle("ct_arb");
         cycle("ct_wait");
         m_ready = 1'b1;
         #1;
         check_eq("ct_grant_seq", 64'(grant), 64'(exp_g));
         cycle("ct_done");
      end
      m_ready = 1'b0;
      s_valid = '0;
      cycle("ct_idle");

      // requester 0 withdraws its request before completion
      s_valid = 2'b01;
      cycle("wd_arb");
      s_valid = 2'b00;
      cycle("wd_drop");
      cycle("wd_idle");
      s_valid = 2'b11;
      cycle("wd_arb2");
      #1;
      check_eq("wd_regrant0", 64'(grant), 64'h0);
      m_ready = 1'b1;
      cycle("wd_done");
      m_ready = 1'b0;
      s_valid = '0;
      cycle("wd_idle2");

      // reset while requester 1 holds the grant
      s_valid = 2'b10;
      cycle("rst_arb");
      #1;
      check_eq("rst_pre_grant", 64'(grant), 64'h1);
      m_ready = 1'b1;
      #1;
      reset = 1'b1;
      #1;
      model_reset();
      check_eq("rst_m_valid", 64'(m_valid), 64'h0);
      check_eq("rst_s_ready", 64'(s_ready), 64'h0);
      check_eq("rst_grant",   64'(grant),   64'h0);
      check_eq("rst_busy",    64'(busy),    64'h0);
      @(posedge clk);
      #1;
      reset   = 1'b0;
      m_ready = 1'b0;
      s_valid = '0;
      cycle("post_rst");

      // randomized traffic, including withdrawals and idle-time m_ready
      for (int i = 0; i < 400; i++) begin
         s_valid = N'($urandom_range(0, 3));
         m_ready = ($urandom_range(0, 2) == 0);
         s_addr  = {$urandom, $urandom};
         s_wdata = {$urandom, $urandom};
         s_wstrb = 8'($urandom);
         m_rdata = $urandom;
         cycle("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
